shift_operand_stage: RTL and testbench

- ID/EX pipeline stage that feeds the 16-bit barrel shifter in the execute stage.
- Each cycle it:
  - selects forwarded source operands;
  - forms the 4-bit shift count from a register or an immediate;
  - registers operand, count and shift op, plus the destination bookkeeping the shifter's result needs downstream.
- Supports stall, flush and bubble insertion, and raises a load-use stall request back to decode.

---
 rtl/shift_operand_stage.sv | 107 ++++++++++
 tb/tb_shift_operand_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_stage.sv
// ID/EX register for the barrel-shifter path: forwards the shift operand and the
// register count, registers operand/count/op/dest, and detects load-use hazards.
module shift_operand_stage #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int R = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [R-1:0] id_src1,
  input  logic [R-1:0] id_src2,
  input  logic [R-1:0] id_dest,
  input  logic         id_reg_write,
  input  logic         id_mem_read,
  input  logic         id_use_imm,
  input  logic         id_shift_op,
  input  logic [N-1:0] id_rd1,
  input  logic [N-1:0] id_rd2,
  input  logic [N-1:0] id_imm,
  input  logic         exm_reg_write,
  input  logic [R-1:0] exm_dest,
  input  logic [N-1:0] exm_data,
  input  logic         mwb_reg_write,
  input  logic [R-1:0] mwb_dest,
  input  logic [N-1:0] mwb_data,
  output logic         ex_valid,
  output logic [N-1:0] ex_shift_in,
  output logic [C-1:0] ex_shift_cnt,
  output logic         ex_shift_op,
  output logic [R-1:0] ex_dest,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         load_use_stall
);

  logic [N-1:0] src1Val;
  logic [N-1:0] src2Val;
  logic [C-1:0] countNext;
  logic         src1Hazard;
  logic         src2Hazard;

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is not special.
  function automatic logic [N-1:0] forwardSource(input logic [R-1:0] src,
                                                 input logic [N-1:0] rd);
    logic [N-1:0] val;
    val = rd;
    if (exm_reg_write && (exm_dest == src))
      val = exm_data;
    else if (mwb_reg_write && (mwb_dest == src))
      val = mwb_data;
    return val;
  endfunction

  always_comb begin
    src1Val   = forwardSource(id_src1, id_rd1);
    src2Val   = forwardSource(id_src2, id_rd2);
    countNext = id_use_imm ? id_imm[C-1:0] : src2Val[C-1:0];
  end

  // The loaded value is not available for forwarding until it reaches MEM/WB.
  always_comb begin
    src1Hazard     = (ex_dest == id_src1);
    src2Hazard     = ~id_use_imm & (ex_dest == id_src2);
    load_use_stall = id_valid & ex_valid & ex_mem_read & ex_reg_write &
                     (src1Hazard | src2Hazard);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_shift_in  <= '0;
      ex_shift_cnt <= '0;
      ex_shift_op  <= 1'b0;
      ex_dest      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (stall) begin
      ex_valid     <= ex_valid;
      ex_shift_in  <= ex_shift_in;
      ex_shift_cnt <= ex_shift_cnt;
      ex_shift_op  <= ex_shift_op;
      ex_dest      <= ex_dest;
      ex_reg_write <= ex_reg_write;
      ex_mem_read  <= ex_mem_read;
    end else if (flush || load_use_stall) begin
      ex_valid     <= 1'b0;
      ex_shift_in  <= '0;
      ex_shift_cnt <= '0;
      ex_shift_op  <= 1'b0;
      ex_dest      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_shift_in  <= src1Val;
      ex_shift_cnt <= countNext;
      ex_shift_op  <= id_shift_op;
      ex_dest      <= id_dest;
      ex_reg_write <= id_reg_write & id_valid;
      ex_mem_read  <= id_mem_read & id_valid;
    end
  end

endmodule

// File: tb/tb_shift_operand_stage.sv
// Directed self-checking bench for shift_operand_stage: reset, capture, forwarding,
// load-use hazard, stall/flush priority and reset during stall.
module tb_shift_operand_stage;

  localparam int N = 16;
  localparam int C = 4;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         rst, stall, flush;
  logic         id_valid, id_reg_write, id_mem_read, id_use_imm, id_shift_op;
  logic [R-1:0] id_src1, id_src2, id_dest;
  logic [N-1:0] id_rd1, id_rd2, id_imm;
  logic         exm_reg_write, mwb_reg_write;
  logic [R-1:0] exm_dest, mwb_dest;
  logic [N-1:0] exm_data, mwb_data;
  logic         ex_valid, ex_shift_op, ex_reg_write, ex_mem_read, load_use_stall;
  logic [N-1:0] ex_shift_in;
  logic [C-1:0] ex_shift_cnt;
  logic [R-1:0] ex_dest;

  int tests  = 0;
  int failed = 0;

  shift_operand_stage #(.N(N), .C(C), .R(R)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_use_imm(id_use_imm),
    .id_shift_op(id_shift_op), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_data(exm_data),
    .mwb_reg_write(mwb_reg_write), .mwb_dest(mwb_dest), .mwb_data(mwb_data),
    .ex_valid(ex_valid), .ex_shift_in(ex_shift_in), .ex_shift_cnt(ex_shift_cnt),
    .ex_shift_op(ex_shift_op), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [N-1:0] sin,
                             input logic [C-1:0] cnt, input logic op, input logic [R-1:0] dst,
                             input logic rw, input logic mr);
    check({tag, ".valid"}, 32'(ex_valid), 32'(v));
    check({tag, ".in"}, 32'(ex_shift_in), 32'(sin));
    check({tag, ".cnt"}, 32'(ex_shift_cnt), 32'(cnt));
    check({tag, ".op"}, 32'(ex_shift_op), 32'(op));
    check({tag, ".dest"}, 32'(ex_dest), 32'(dst));
    check({tag, ".rw"}, 32'(ex_reg_write), 32'(rw));
    check({tag, ".mr"}, 32'(ex_mem_read), 32'(mr));
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    id_valid = 1; id_src1 = 1; id_src2 = 2; id_dest = 7;
    id_reg_write = 1; id_mem_read = 1; id_use_imm = 0; id_shift_op = 1;
    id_rd1 = 16'hFFFF; id_rd2 = 16'hFFFF; id_imm = 16'hFFFF;
    exm_reg_write = 0; exm_dest = 0; exm_data = 0;
    mwb_reg_write = 0; mwb_dest = 0; mwb_data = 0;

    // Reset held two cycles with valid ID inputs
    applyStimulus();
    applyStimulus();
    checkOutput("reset", 0, 16'h0, 4'h0, 0, 3'd0, 0, 0);
    check("reset.lus", 32'(load_use_stall), 32'h0);

    // Plain capture on first edge after reset
    @(negedge clk);
    rst = 0; id_rd1 = 16'hA5F0; id_use_imm = 1; id_imm = 16'h0004;
    id_shift_op = 1; id_dest = 3; id_mem_read = 0; id_src1 = 1; id_src2 = 0;
    applyStimulus();
    checkOutput("plain", 1, 16'hA5F0, 4'd4, 1, 3'd3, 1, 0);

    // Both forwarding stages match src1: EX/MEM wins; register count 0x13 -> 3
    @(negedge clk);
    id_src1 = 2; id_rd1 = 16'hDEAD; id_src2 = 4; id_rd2 = 16'h0013; id_use_imm = 0;
    id_shift_op = 0; id_dest = 1;
    exm_reg_write = 1; exm_dest = 2; exm_data = 16'h1234;
    mwb_reg_write = 1; mwb_dest = 2; mwb_data = 16'h5678;
    applyStimulus();
    checkOutput("fwd_exm", 1, 16'h1234, 4'd3, 0, 3'd1, 1, 0);

    @(negedge clk);
    exm_reg_write = 0;
    applyStimulus();
    check("fwd_mwb.in", 32'(ex_shift_in), 32'h5678);

    // r0 forwards like any register, on both operand and count
    @(negedge clk);
    id_src1 = 0; id_src2 = 0; mwb_dest = 0; mwb_data = 16'h0BAD;
    applyStimulus();
    check("fwd_r0.in", 32'(ex_shift_in), 32'h0BAD);
    check("fwd_r0.cnt", 32'(ex_shift_cnt), 32'hD);

    // Immediate count of 16 wraps to 0
    @(negedge clk);
    mwb_reg_write = 0; id_use_imm = 1; id_imm = 16'h0010; id_rd1 = 16'h00FF; id_src1 = 1;
    applyStimulus();
    check("wrap.cnt", 32'(ex_shift_cnt), 32'h0);
    check("wrap.in", 32'(ex_shift_in), 32'h00FF);

    // Invalid instruction: write/load flags masked, data still captured
    @(negedge clk);
    id_valid = 0; id_mem_read = 1; id_reg_write = 1; id_rd1 = 16'h3C3C; id_imm = 16'h0002;
    applyStimulus();
    checkOutput("invalid", 0, 16'h3C3C, 4'd2, 0, 3'd1, 0, 0);

    // Load to r5 enters EX
    @(negedge clk);
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_dest = 5; id_rd1 = 16'h0001;
    applyStimulus();
    check("load.mr", 32'(ex_mem_read), 32'h1);

    // Dependent shift on src2=5 with register count
    @(negedge clk);
    id_mem_read = 0; id_src1 = 1; id_src2 = 5; id_use_imm = 0; id_dest = 6;
    id_rd1 = 16'h8001; id_rd2 = 16'h0002; id_shift_op = 1;
    #1;
    check("lu_src2.lus", 32'(load_use_stall), 32'h1);
    applyStimulus();
    checkOutput("lu_bubble", 0, 16'h0, 4'd0, 0, 3'd0, 0, 0);
    check("lu_bubble.lus", 32'(load_use_stall), 32'h0);
    applyStimulus();
    checkOutput("lu_resume", 1, 16'h8001, 4'd2, 1, 3'd6, 1, 0);

    // Load to r5 again; immediate count with src1!=5 must not stall, src1==5 must
    @(negedge clk);
    id_mem_read = 1; id_dest = 5;
    applyStimulus();
    @(negedge clk);
    id_mem_read = 0; id_use_imm = 1; id_src1 = 2; id_src2 = 5; id_dest = 4;
    #1;
    check("lu_imm.lus", 32'(load_use_stall), 32'h0);
    id_src1 = 5;
    #1;
    check("lu_src1.lus", 32'(load_use_stall), 32'h1);
    applyStimulus();
    check("lu_src1_bubble.valid", 32'(ex_valid), 32'h0);

    // Capture a known instruction, then stall three cycles with changing inputs
    @(negedge clk);
    id_src1 = 3; id_rd1 = 16'h4321; id_imm = 16'h0007; id_use_imm = 1;
    id_shift_op = 0; id_dest = 2; id_reg_write = 1; id_mem_read = 0;
    applyStimulus();
    checkOutput("pre_stall", 1, 16'h4321, 4'd7, 0, 3'd2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1; id_rd1 = 16'h1111 * N'(i + 1); id_imm = N'(i + 9);
      id_dest = R'(i); id_shift_op = 1; id_valid = i[0];
      applyStimulus();
      checkOutput($sformatf("stall%0d", i), 1, 16'h4321, 4'd7, 0, 3'd2, 1, 0);
    end

    // Stall beats flush
    @(negedge clk);
    flush = 1; id_valid = 1;
    applyStimulus();
    checkOutput("stall_flush", 1, 16'h4321, 4'd7, 0, 3'd2, 1, 0);

    // Flush alone inserts a bubble
    @(negedge clk);
    stall = 0;
    applyStimulus();
    checkOutput("flush", 0, 16'h0, 4'd0, 0, 3'd0, 0, 0);

    // Reset during a stall clears a valid stage
    @(negedge clk);
    flush = 0; id_rd1 = 16'h7777; id_dest = 3;
    applyStimulus();
    check("pre_rst.valid", 32'(ex_valid), 32'h1);
    @(negedge clk);
    stall = 1; rst = 1;
    applyStimulus();
    checkOutput("rst_stall", 0, 16'h0, 4'd0, 0, 3'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
